mux4_tx: RTL and testbench

- Transmit-side 4:1 multiplexer; the counterpart of the team's 1:4 demux.
- Collects words from four source channels and serialises them onto one output stream. Each word is tagged with a 2-bit select {a,b} that tells the downstream demux which output (z0..z3) the word belongs to.
- Round-robin arbitration, valid/ready handshakes on every channel, one registered output stage, and a running count of transferred words.

---
 rtl/mux4_tx.sv | 133 +++++++++++++
 tb/tb_mux4_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux4_tx.sv
// mux4_tx: transmit-side 4:1 multiplexer.
// Serialises words from four valid/ready source channels onto one registered output stream.
// Each output word carries its channel index on {out_a,out_b} for the downstream 1:4 demux.
// Arbitration is round-robin by default. Define MUX4_FIXED_PRIO_EN to switch to fixed
// priority, with channel 0 highest.
module mux4_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_a,
  output logic               out_b,
  output logic [CNT_W-1:0]   word_cnt
);

  // The output register is either empty or holding one word.
  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             load;
  logic             grant_vld;
  logic [1:0]       grant_idx;
  logic             in_xfer;
  logic             out_xfer;

`ifndef MUX4_FIXED_PRIO_EN
  // Index of the most recently granted channel. The search starts just after it.
  logic [1:0]       ptr_q, ptr_d;
`endif

  // A new word may be loaded when the register is empty or is being drained this cycle.
  assign load     = (state_q == StEmpty) || out_ready;
  assign out_xfer = (state_q == StFull) && out_ready;
  assign in_xfer  = grant_vld && load && rst_n;

  // Pick one requesting channel. The loop runs from the lowest to the highest search
  // priority, so the highest-priority requester is the last one written and wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
`ifdef MUX4_FIXED_PRIO_EN
    for (int k = 3; k >= 0; k--) begin
      if (in_valid[k]) begin
        grant_vld = 1'b1;
        grant_idx = 2'(k);
      end
    end
`else
    for (int k = 4; k >= 1; k--) begin
      if (in_valid[2'(ptr_q + 2'(k))]) begin
        grant_vld = 1'b1;
        grant_idx = 2'(ptr_q + 2'(k));
      end
    end
`endif
  end

  // Only the granted channel sees ready. Ready is held low while reset is asserted.
  always_comb begin
    in_ready = 4'b0000;
    if (in_xfer) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state logic for the output register, the word counter and the grant pointer.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
`ifndef MUX4_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif

    unique case (state_q)
      StEmpty: if (in_xfer) state_d = StFull;
      StFull:  if (out_xfer && !in_xfer) state_d = StEmpty;
    endcase

    if (in_xfer) begin
      data_d = in_data[grant_idx*WIDTH +: WIDTH];
      sel_d  = grant_idx;
`ifndef MUX4_FIXED_PRIO_EN
      ptr_d  = grant_idx;
`endif
    end

    // The counter wraps naturally and does not saturate.
    if (out_xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
`ifndef MUX4_FIXED_PRIO_EN
      ptr_q   <= 2'd3;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
`ifndef MUX4_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_a     = sel_q[1];
  assign out_b     = sel_q[0];
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_mux4_tx.sv
// Directed self-checking bench for mux4_tx.
// A second instance with a 4-bit counter shares all of the inputs and is used to exercise
// counter wrap-around.
module tb_mux4_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready, in_ready4;
  logic        out_valid, out_valid4;
  logic        out_ready;
  logic [7:0]  out_data, out_data4;
  logic        out_a, out_b, out_a4, out_b4;
  logic [15:0] word_cnt;
  logic [3:0]  word_cnt4;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rr_word [4] = '{8'h10, 8'h21, 8'h32, 8'h43};

  always #5 clk = ~clk;

  mux4_tx #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_a(out_a),
    .out_b(out_b), .word_cnt(word_cnt)
  );

  mux4_tx #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_a(out_a4),
    .out_b(out_b4), .word_cnt(word_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_ch;

    // Reset held for three cycles while every channel requests.
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_cnt", 32'(word_cnt), 32'h0);
    chk("rst_sel", 32'({out_a, out_b}), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);

    // After release the first grant goes to channel 0.
    rst_n = 1'b1;
    #1;
    chk("first_grant", 32'(in_ready), 32'b0001);
    tick();
    in_valid = 4'b0000;
    #1;
    chk("first_valid", 32'(out_valid), 32'h1);
    chk("first_data", 32'(out_data), 32'h10);
    chk("first_sel", 32'({out_a, out_b}), 32'h0);
    tick();
    chk("first_cnt", 32'(word_cnt), 32'h1);
    chk("first_empty", 32'(out_valid), 32'h0);

    // A single request on channel 2.
    in_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    in_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(in_ready), 32'b0100);
    tick();
    in_valid = 4'b0000;
    #1;
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_data", 32'(out_data), 32'hA5);
    chk("single_a", 32'(out_a), 32'h1);
    chk("single_b", 32'(out_b), 32'h0);
    tick();
    chk("single_cnt", 32'(word_cnt), 32'h2);

    // All four channels request continuously for eight cycles, starting from reset.
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    in_valid = 4'b1111;
    in_data  = {8'h43, 8'h32, 8'h21, 8'h10};
    #1;
    for (int k = 0; k < 8; k++) begin
`ifdef MUX4_FIXED_PRIO_EN
      exp_ch = 0;
`else
      exp_ch = k % 4;
`endif
      chk("rr_ready", 32'(in_ready), 32'(1 << exp_ch));
      tick();
      chk("rr_sel", 32'({out_a, out_b}), 32'(exp_ch));
      chk("rr_data", 32'(out_data), 32'(rr_word[exp_ch]));
      chk("rr_valid", 32'(out_valid), 32'h1);
    end
    in_valid = 4'b0000;
    tick();
    chk("rr_cnt", 32'(word_cnt), 32'h8);
    chk("rr_cnt4", 32'(word_cnt4), 32'h8);
    chk("rr_empty", 32'(out_valid), 32'h0);

    // Backpressure: a word from channel 1 is held while channel 2 also waits.
    in_data   = {8'h00, 8'h32, 8'h3C, 8'h00};
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(in_ready), 32'b0010);
    tick();
    in_valid = 4'b0110;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_ready", 32'(in_ready), 32'h0);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_data", 32'(out_data), 32'h3C);
      chk("bp_sel", 32'({out_a, out_b}), 32'h1);
      chk("bp_cnt", 32'(word_cnt), 32'h8);
      tick();
    end
    out_ready = 1'b1;
    #1;
`ifdef MUX4_FIXED_PRIO_EN
    chk("bp_release", 32'(in_ready), 32'b0010);
`else
    chk("bp_release", 32'(in_ready), 32'b0100);
`endif
    tick();
    in_valid = 4'b0000;
    #1;
    chk("bp_cnt_after", 32'(word_cnt), 32'h9);
    chk("bp_next_valid", 32'(out_valid), 32'h1);
`ifdef MUX4_FIXED_PRIO_EN
    chk("bp_next_data", 32'(out_data), 32'h3C);
    chk("bp_next_sel", 32'({out_a, out_b}), 32'h1);
`else
    chk("bp_next_data", 32'(out_data), 32'h32);
    chk("bp_next_sel", 32'({out_a, out_b}), 32'h2);
`endif
    tick();
    chk("bp_cnt_drain", 32'(word_cnt), 32'hA);
    chk("bp_empty", 32'(out_valid), 32'h0);

    // Reset while a word is held under backpressure.
    in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    tick();
    chk("mid_full", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_ready_rst", 32'(in_ready), 32'h0);
    tick();
    chk("mid_valid", 32'(out_valid), 32'h0);
    chk("mid_cnt", 32'(word_cnt), 32'h0);
    chk("mid_data", 32'(out_data), 32'h0);
    chk("mid_sel", 32'({out_a, out_b}), 32'h0);
    rst_n     = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("mid_grant", 32'(in_ready), 32'b0001);

    // Counter wrap on the 4-bit instance: 16 transfers, then a 17th.
    repeat (16) tick();
    in_valid = 4'b0000;
    tick();
    chk("wrap16_cnt4", 32'(word_cnt4), 32'h0);
    chk("wrap16_cnt", 32'(word_cnt), 32'h10);
    in_valid = 4'b0001;
    tick();
    in_valid = 4'b0000;
    tick();
    chk("wrap17_cnt4", 32'(word_cnt4), 32'h1);
    chk("wrap17_cnt", 32'(word_cnt), 32'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
